// File: rtl/grad_update_sched.sv
// Periodic update scheduler feeding the OCRA1 gradient serialiser.
// Optional macro GRAD_SCHED_COUNT_EN enables the issued-transfer counter on update_cnt_o.
module grad_update_sched #(
  parameter int INTERVAL_W = 16,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [INTERVAL_W-1:0] interval_i,
  input  logic [95:0]           in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [23:0]           datax_o,
  output logic [23:0]           datay_o,
  output logic [23:0]           dataz_o,
  output logic [23:0]           dataz2_o,
  output logic                  valid_o,
  input  logic                  busy_i,
  output logic                  running_o,
  output logic                  overrun_o,
  output logic                  underrun_o,
  input  logic                  clr_err_i,
  output logic [CNT_W-1:0]      update_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam logic [INTERVAL_W-1:0] T_ZERO = {INTERVAL_W{1'b0}};
  localparam logic [INTERVAL_W-1:0] T_ONE  = {{(INTERVAL_W-1){1'b0}}, 1'b1};
  localparam logic [INTERVAL_W-1:0] T_TWO  = {{(INTERVAL_W-2){1'b0}}, 2'b10};

  state_t                  state_q, state_d;
  logic [INTERVAL_W-1:0]   timer_q, timer_d;
  logic [INTERVAL_W-1:0]   interval_q, interval_d;
  logic [INTERVAL_W-1:0]   interval_eff_s;
  logic [95:0]             data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    running_q, running_d;
  logic                    overrun_q, overrun_d;
  logic                    underrun_q, underrun_d;
  logic                    tick_s;
  logic                    accept_s;
  logic                    start_s;
  logic                    ov_set_s;
  logic                    un_set_s;

  assign interval_eff_s = (interval_i < T_TWO) ? T_TWO : interval_i;
  assign tick_s         = (timer_q == T_ZERO);
  assign start_s        = (state_q == IDLE) && start_i && !stop_i;

  // Next-state, accept decision and error-flag update.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    interval_d = interval_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    running_d  = running_q;
    accept_s   = 1'b0;
    ov_set_s   = 1'b0;
    un_set_s   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_s) begin
          state_d    = RUN;
          interval_d = interval_eff_s;
          timer_d    = interval_eff_s - T_ONE;
          running_d  = 1'b1;
        end else begin
          state_d   = IDLE;
          running_d = 1'b0;
        end
      end
      RUN: begin
        if (stop_i) begin
          state_d   = IDLE;
          timer_d   = T_ZERO;
          running_d = 1'b0;
        end else begin
          // Reload on tick keeps the period fixed whatever happens downstream.
          timer_d = tick_s ? (interval_q - T_ONE) : (timer_q - T_ONE);
          if (tick_s && in_valid_i && !busy_i) begin
            accept_s = 1'b1;
          end else if (tick_s && !in_valid_i) begin
            un_set_s = 1'b1;
          end else if (tick_s) begin
            ov_set_s = 1'b1;
            state_d  = PEND;
          end else begin
            state_d = RUN;
          end
        end
      end
      PEND: begin
        if (stop_i) begin
          state_d   = IDLE;
          timer_d   = T_ZERO;
          running_d = 1'b0;
        end else begin
          timer_d  = tick_s ? (interval_q - T_ONE) : (timer_q - T_ONE);
          ov_set_s = tick_s;
          if (in_valid_i && !busy_i) begin
            accept_s = 1'b1;
            state_d  = RUN;
          end else begin
            state_d = PEND;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        timer_d   = T_ZERO;
        running_d = 1'b0;
      end
    endcase

    if (accept_s) begin
      data_d  = in_data_i;
      valid_d = 1'b1;
    end else begin
      data_d  = data_q;
      valid_d = 1'b0;
    end

    // A set in the same cycle as a clear takes priority.
    if (ov_set_s) begin
      overrun_d = 1'b1;
    end else if (clr_err_i) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    if (un_set_s) begin
      underrun_d = 1'b1;
    end else if (clr_err_i) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      timer_q    <= T_ZERO;
      interval_q <= T_ZERO;
      data_q     <= 96'd0;
      valid_q    <= 1'b0;
      running_q  <= 1'b0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      interval_q <= interval_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      running_q  <= running_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

`ifdef GRAD_SCHED_COUNT_EN
  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter steps on the accept edge so it changes together with valid_o.
  always_comb begin
    if (start_s) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (accept_s) begin
      cnt_d = cnt_q + C_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign update_cnt_o = cnt_q;
`else
  assign update_cnt_o = {CNT_W{1'b0}};
`endif

  // in_ready_o is the same-cycle accept strobe; it must follow busy_i/in_valid_i directly.
  assign in_ready_o = accept_s;
  assign datax_o    = data_q[23:0];
  assign datay_o    = data_q[47:24];
  assign dataz_o    = data_q[71:48];
  assign dataz2_o   = data_q[95:72];
  assign valid_o    = valid_q;
  assign running_o  = running_q;
  assign overrun_o  = overrun_q;
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_grad_update_sched.sv
// Randomized self-checking bench for grad_update_sched against a period-arithmetic reference model.
module tb_grad_update_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i, stop_i, in_valid_i, busy_i, clr_err_i;
  logic [15:0] interval_i;
  logic [95:0] in_data_i;
  logic        in_ready_o, valid_o, running_o, overrun_o, underrun_o;
  logic [23:0] datax_o, datay_o, dataz_o, dataz2_o;
  logic [31:0] update_cnt_o;

  always #5 clk = ~clk;

  grad_update_sched dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .stop_i(stop_i),
    .interval_i(interval_i), .in_data_i(in_data_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .datax_o(datax_o), .datay_o(datay_o),
    .dataz_o(dataz_o), .dataz2_o(dataz2_o), .valid_o(valid_o), .busy_i(busy_i),
    .running_o(running_o), .overrun_o(overrun_o), .underrun_o(underrun_o),
    .clr_err_i(clr_err_i), .update_cnt_o(update_cnt_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: ticks are every m_per cycles after the start cycle.
  bit          m_run, m_pend, m_valid, m_ov, m_un;
  int          m_start, m_per, cyc;
  logic [95:0] m_data;
  logic [31:0] m_cnt;
  int          n_valid_seen;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt();
`ifdef GRAD_SCHED_COUNT_EN
    return m_cnt;
`else
    return 32'd0;
`endif
  endfunction

  task automatic compare_outputs(input bit exp_rdy);
    check_eq("in_ready", 32'(in_ready_o), 32'(exp_rdy));
    check_eq("valid",    32'(valid_o),    32'(m_valid));
    check_eq("running",  32'(running_o),  32'(m_run));
    check_eq("overrun",  32'(overrun_o),  32'(m_ov));
    check_eq("underrun", 32'(underrun_o), 32'(m_un));
    check_eq("datax",    32'(datax_o),    32'(m_data[23:0]));
    check_eq("datay",    32'(datay_o),    32'(m_data[47:24]));
    check_eq("dataz",    32'(dataz_o),    32'(m_data[71:48]));
    check_eq("dataz2",   32'(dataz2_o),   32'(m_data[95:72]));
    check_eq("update_cnt", update_cnt_o, exp_cnt());
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_pend = 1'b0; m_valid = 1'b0; m_ov = 1'b0; m_un = 1'b0;
    m_data = 96'd0; m_cnt = 32'd0;
  endtask

  // One clock cycle: inputs already applied; compare at negedge, then advance.
  task automatic step();
    bit tick, acc, ovs, uns, n_run, n_pend;
    @(negedge clk);
    tick = m_run && (cyc > m_start) && (((cyc - m_start) % m_per) == 0);
    acc = 1'b0; ovs = 1'b0; uns = 1'b0;
    n_run = m_run; n_pend = m_pend;
    if (!m_run) begin
      if (start_i && !stop_i) begin
        n_run = 1'b1; n_pend = 1'b0;
      end
    end else if (stop_i) begin
      n_run = 1'b0; n_pend = 1'b0;
    end else if (!m_pend) begin
      if (tick) begin
        if (in_valid_i && !busy_i) acc = 1'b1;
        else if (!in_valid_i) uns = 1'b1;
        else begin ovs = 1'b1; n_pend = 1'b1; end
      end
    end else begin
      if (tick) ovs = 1'b1;
      if (in_valid_i && !busy_i) begin acc = 1'b1; n_pend = 1'b0; end
    end
    compare_outputs(acc);
    if (m_valid) n_valid_seen++;
    if (!m_run && n_run) begin
      m_per = (interval_i < 16'd2) ? 2 : int'(interval_i);
      m_start = cyc;
      m_cnt = 32'd0;
    end
    m_run = n_run; m_pend = n_pend;
    m_valid = acc;
    if (acc) begin m_data = in_data_i; m_cnt = m_cnt + 32'd1; end
    m_ov = ovs ? 1'b1 : (clr_err_i ? 1'b0 : m_ov);
    m_un = uns ? 1'b1 : (clr_err_i ? 1'b0 : m_un);
    @(posedge clk);
    #1;
    cyc++;
    in_data_i = {$urandom(), $urandom(), $urandom()};
  endtask

  task automatic set_in(input bit st, input bit sp, input logic [15:0] iv,
                        input bit v, input bit b, input bit c);
    start_i = st; stop_i = sp; interval_i = iv; in_valid_i = v; busy_i = b; clr_err_i = c;
  endtask

  // Asynchronous reset mid-cycle: outputs must clear without waiting for a clock edge.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1 compare_outputs(1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    cyc = 0; m_start = 0; m_per = 2; n_valid_seen = 0;
    set_in(1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    in_data_i = 96'd0;
    rst_n = 1'b0;
    model_reset();
    #3 compare_outputs(1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Steady run, interval 10: first valid at start+11 then every 10 cycles.
    set_in(1'b1, 1'b0, 16'd10, 1'b1, 1'b0, 1'b0);
    step();
    set_in(1'b0, 1'b0, 16'd10, 1'b1, 1'b0, 1'b0);
    repeat (35) step();
    check_eq("valid_count_run10", 32'(n_valid_seen), 32'd3);

    // Underrun over one period, then clear.
    in_valid_i = 1'b0;
    repeat (10) step();
    in_valid_i = 1'b1;
    repeat (3) step();
    clr_err_i = 1'b1; step(); clr_err_i = 1'b0;

    // Busy stretching past a tick drives PEND and overrun.
    busy_i = 1'b1;
    repeat (12) step();
    busy_i = 1'b0;
    repeat (25) step();

    // Start and stop together from IDLE stay idle; then interval 0 behaves as 2.
    set_in(1'b0, 1'b1, 16'd0, 1'b1, 1'b0, 1'b1);
    step();
    set_in(1'b1, 1'b1, 16'd0, 1'b1, 1'b0, 1'b0);
    repeat (3) step();
    set_in(1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    step();
    start_i = 1'b0;
    repeat (12) step();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      start_i    = ($urandom_range(0, 39) == 0);
      stop_i     = ($urandom_range(0, 59) == 0);
      interval_i = 16'($urandom_range(0, 12));
      in_valid_i = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 4) == 0) busy_i = ~busy_i;
      clr_err_i  = ($urandom_range(0, 24) == 0);
      step();
    end

    // Reset while a transfer is pending; nothing may issue afterwards.
    set_in(1'b0, 1'b1, 16'd4, 1'b1, 1'b1, 1'b0);
    step();
    set_in(1'b1, 1'b0, 16'd4, 1'b1, 1'b1, 1'b0);
    step();
    start_i = 1'b0;
    for (int i = 0; i < 10 && !m_pend; i++) step();
    check_eq("reached_pend", 32'(m_pend), 32'd1);
    async_reset();
    busy_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_valid_i = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/grad_update_sched.md
GRAD_UPDATE_SCHED -- requirements
Module: grad_update_sched

Interface
REQ-001 SHALL have parameter INTERVAL_W, default 16, width of update-interval and timer fields.
REQ-002 SHALL have parameter CNT_W, default 32, width of update counter.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start_i  input  1  one-cycle pulse, begin periodic updates.
REQ-006 SHALL have port stop_i  input  1  one-cycle pulse, end periodic updates.
REQ-007 SHALL have port interval_i  input  INTERVAL_W  clock cycles between update ticks; sampled at start.
REQ-008 SHALL have port in_data_i  input  96  upstream sample {z2,z,y,x}, 24 bits each, x in [23:0].
REQ-009 SHALL have port in_valid_i  input  1  upstream sample available.
REQ-010 SHALL have port in_ready_o  output  1  one-cycle accept strobe to upstream.
REQ-011 SHALL have ports datax_o, datay_o, dataz_o, dataz2_o  output  24 each  words to OCRA1 serialiser.
REQ-012 SHALL have port valid_o  output  1  one-cycle transfer-start pulse to serialiser.
REQ-013 SHALL have port busy_i  input  1  serialiser SPI transfer in progress.
REQ-014 SHALL have ports running_o, overrun_o, underrun_o  output  1 each  status; error flags sticky.
REQ-015 SHALL have port clr_err_i  input  1  clears sticky error flags.
REQ-016 SHALL have port update_cnt_o  output  CNT_W  count of issued transfers.

Function
REQ-017 SHALL implement states IDLE, RUN, PEND.
REQ-018 IDLE->RUN on start_i: latch interval (values 0 or 1 treated as 2), load timer with latched interval-1, clear update_cnt_o, assert running_o.
REQ-019 In RUN, timer SHALL decrement each cycle; tick occurs on the cycle timer==0; timer reloads to interval-1 on tick, keeping exact period regardless of PEND.
REQ-020 Tick with in_valid_i=1, busy_i=0: in_ready_o=1 that cycle, data latched into data*_o, valid_o=1 on next cycle only (latency 1), update_cnt_o increments with valid_o.
REQ-021 Tick with in_valid_i=0: set underrun_o, no valid_o, data*_o hold previous values, stay RUN.
REQ-022 Tick with in_valid_i=1, busy_i=1: set overrun_o, go PEND; in PEND, on first cycle busy_i=0 perform REQ-020 accept/issue, return RUN.
REQ-023 Tick arriving while in PEND SHALL be dropped and set overrun_o (no second queued transfer).
REQ-024 in_ready_o SHALL never assert outside an accept cycle; upstream sample SHALL NOT be consumed without a following valid_o.
REQ-025 stop_i in RUN/PEND: go IDLE next cycle, deassert running_o; a valid_o already scheduled for next cycle SHALL still be emitted; PEND pending transfer discarded.
REQ-026 start_i and stop_i same cycle: stop wins; start_i in RUN/PEND ignored.
REQ-027 clr_err_i SHALL clear error flags; same-cycle set event wins over clear.
REQ-028 update_cnt_o SHALL wrap modulo 2^CNT_W.

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, timer 0, data*_o 0, valid_o 0, in_ready_o 0, running_o 0, overrun_o 0, underrun_o 0, update_cnt_o 0.
REQ-030 Reset mid-transfer SHALL abandon any pending transfer; no valid_o after release until a new start_i.

Configuration
REQ-031 Macro GRAD_SCHED_COUNT_EN: defined -> update counter per REQ-016/020/028; undefined -> no counter logic, update_cnt_o tied to 0.

Verification
REQ-032 start_i, interval_i=10, in_valid_i=1, busy_i=0 -> valid_o pulses every 10 cycles, first at start+11, update_cnt_o 1,2,3.
REQ-033 interval_i=10, in_valid_i=0 at second tick -> underrun_o=1, no valid_o that period, data*_o unchanged; clr_err_i -> underrun_o=0.
REQ-034 busy_i held high 4 cycles past a tick -> overrun_o=1, in_ready_o and valid_o issued on first cycle busy_i=0 (+1), next tick still at original period.
REQ-035 interval_i=0 -> ticks every 2 cycles; start_i and stop_i same cycle -> stays IDLE, running_o=0.
REQ-036 rst_n low during PEND -> all outputs 0 immediately, no valid_o after release; build without GRAD_SCHED_COUNT_EN -> update_cnt_o always 0.
